// File: rtl/z80_bus_mem.sv
// Z80 bus-attached memory model: 64 KiB memory, 256-byte I/O space, host preload port.
// Wait-state insertion is compiled in only when BUS_WAIT_STATES_EN is defined.
module z80_bus_mem #(
    parameter int unsigned MEM_WAIT    = 0,
    parameter int unsigned IO_WAIT     = 1,
    parameter logic [7:0]  INTACK_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  di,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic [15:0] wr_count
);

`ifdef BUS_WAIT_STATES_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MEM_N = WAIT_EN ? CNT_W'(MEM_WAIT) : '0;
    localparam logic [CNT_W-1:0] IO_N  = WAIT_EN ? CNT_W'(IO_WAIT)  : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cyc_mem;
    logic             cyc_ack;

    logic [7:0] mem [0:65535];
    logic [7:0] io  [0:255];

    logic             intack_c;
    logic             cyc_start_c;
    logic [CNT_W-1:0] start_wait_c;
    logic             kind_mem_c;
    logic             kind_ack_c;
    logic             hold_entry_c;
    logic             commit_c;
    logic             mem_we_c;
    logic             io_we_c;
    logic             load_we_c;

    // Cycle decode; interrupt acknowledge starts a cycle without rd_n/wr_n.
    always_comb begin
        intack_c     = !m1_n && !iorq_n;
        cyc_start_c  = (state == S_IDLE) && rfsh_n && (!mreq_n || !iorq_n)
                       && (!rd_n || !wr_n || intack_c);
        start_wait_c = !mreq_n ? MEM_N : IO_N;
        kind_mem_c   = (state == S_IDLE) ? !mreq_n : cyc_mem;
        kind_ack_c   = (state == S_IDLE) ? (mreq_n && intack_c) : cyc_ack;
        hold_entry_c = (cyc_start_c && (start_wait_c == '0))
                       || ((state == S_WAIT) && (cnt <= CNT_W'(1)));
        commit_c     = !reset && hold_entry_c && !wr_n;
        mem_we_c     = commit_c && kind_mem_c;
        io_we_c      = commit_c && !kind_mem_c && !kind_ack_c;
        load_we_c    = load_en && load_ready;
    end

    assign load_ready = !reset && (state == S_IDLE) && !cyc_start_c;

    // Storage is never reset; bus writes and preloads are mutually exclusive.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[A] <= cpu_dout;
        end else if (load_we_c) begin
            mem[load_addr] <= load_data;
        end
        if (io_we_c) begin
            io[A[7:0]] <= cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cyc_mem  <= 1'b0;
            cyc_ack  <= 1'b0;
            wait_n   <= 1'b1;
            di       <= 8'h00;
            wr_count <= 16'h0000;
        end else begin
            if (!mreq_n) begin
                di <= mem[A];
            end else if (!iorq_n && m1_n) begin
                di <= io[A[7:0]];
            end else if (!iorq_n && !m1_n) begin
                di <= INTACK_BYTE;
            end

            if (mem_we_c) begin
                wr_count <= wr_count + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (cyc_start_c) begin
                        cyc_mem <= kind_mem_c;
                        cyc_ack <= kind_ack_c;
                        if (start_wait_c == '0) begin
                            state <= S_HOLD;
                        end else begin
                            state  <= S_WAIT;
                            cnt    <= start_wait_c;
                            wait_n <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state  <= S_HOLD;
                        cnt    <= '0;
                        wait_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (mreq_n && iorq_n) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wait_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_mem.sv
// Directed bench for z80_bus_mem; expectations follow the active BUS_WAIT_STATES_EN build.
module tb_z80_bus_mem;

`ifdef BUS_WAIT_STATES_EN
    localparam int MEM_WS = 2;
    localparam int IO_WS  = 1;
`else
    localparam int MEM_WS = 0;
    localparam int IO_WS  = 0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic [7:0]  di;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic        wait_n;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic        load_ready;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int waits;

    z80_bus_mem #(
        .MEM_WAIT(2),
        .IO_WAIT(1),
        .INTACK_BYTE(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .A(A),
        .cpu_dout(cpu_dout),
        .di(di),
        .m1_n(m1_n),
        .mreq_n(mreq_n),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .rfsh_n(rfsh_n),
        .wait_n(wait_n),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_ready(load_ready),
        .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic hold_cycles(input int n, output int w);
        w = 0;
        repeat (n) begin
            tick();
            if (wait_n === 1'b0) w++;
        end
    endtask

    task automatic mem_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        int w;
        A = addr; mreq_n = 1'b0; rd_n = 1'b0;
        hold_cycles(4, w);
        check(tag, 32'(di), 32'(exp));
        idle_bus();
        tick();
    endtask

    task automatic io_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        int w;
        A = addr; iorq_n = 1'b0; rd_n = 1'b0;
        hold_cycles(4, w);
        check(tag, 32'(di), 32'(exp));
        idle_bus();
        tick();
    endtask

    task automatic mem_write(input logic [15:0] addr, input logic [7:0] data, input int n, output int w);
        A = addr; cpu_dout = data; mreq_n = 1'b0; wr_n = 1'b0;
        hold_cycles(n, w);
        idle_bus();
        tick();
    endtask

    task automatic preload(input logic [15:0] addr, input logic [7:0] data);
        load_en = 1'b1; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; A = 16'h0000; cpu_dout = 8'h00;
        load_en = 1'b0; load_addr = 16'h0000; load_data = 8'h00;
        idle_bus();

        tick(); tick();
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_di", 32'(di), 32'h00);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_load_ready", 32'(load_ready), 32'd1);

        preload(16'hB5A8, 8'hA6);
        preload(16'h0000, 8'h11);
        preload(16'h1234, 8'h3C);
        mem_read(16'hB5A8, 8'hA6, "preload_read");
        check("preload_wr_count", 32'(wr_count), 32'd0);

        mem_write(16'hB5A8, 8'hB6, 3, waits);
        check("mem_wr_waits", 32'(waits), 32'(MEM_WS));
        check("mem_wr_count", 32'(wr_count), 32'd1);
        mem_read(16'hB5A8, 8'hB6, "raw_read");

        A = 16'h7710; cpu_dout = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
        hold_cycles(3, waits);
        idle_bus(); tick();
        check("io_wr_waits", 32'(waits), 32'(IO_WS));
        check("io_wr_count", 32'(wr_count), 32'd1);
        io_read(16'h0010, 8'h5A, "io_read");

        // Acknowledge with wr_n low must still not touch io[].
        A = 16'h0010; cpu_dout = 8'hEE; m1_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        hold_cycles(3, waits);
        check("intack_di", 32'(di), 32'hFF);
        check("intack_waits", 32'(waits), 32'(IO_WS));
        idle_bus(); tick();
        io_read(16'h0010, 8'h5A, "intack_io_kept");
        check("intack_wr_count", 32'(wr_count), 32'd1);

        A = 16'h0000; cpu_dout = 8'h99; mreq_n = 1'b0; rfsh_n = 1'b0; wr_n = 1'b0;
        hold_cycles(3, waits);
        check("rfsh_waits", 32'(waits), 32'd0);
        idle_bus(); tick();
        mem_read(16'h0000, 8'h11, "rfsh_no_write");
        check("rfsh_wr_count", 32'(wr_count), 32'd1);

        A = 16'h4000; cpu_dout = 8'h55; mreq_n = 1'b0; wr_n = 1'b0;
        load_en = 1'b1; load_addr = 16'h1234; load_data = 8'h77;
        #1;
        check("collide_load_ready", 32'(load_ready), 32'd0);
        tick();
        load_en = 1'b0;
        hold_cycles(2, waits);
        idle_bus(); tick();
        mem_read(16'h1234, 8'h3C, "load_dropped");
        mem_read(16'h4000, 8'h55, "collide_bus_write");
        check("collide_wr_count", 32'(wr_count), 32'd2);

`ifdef BUS_WAIT_STATES_EN
        A = 16'h0000; cpu_dout = 8'hEE; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        check("abort_in_wait", 32'(wait_n), 32'd0);
        reset = 1'b1; idle_bus();
        tick();
`else
        A = 16'h0000; cpu_dout = 8'hEE; mreq_n = 1'b0; wr_n = 1'b0; reset = 1'b1;
        tick();
        idle_bus();
        tick();
`endif
        check("abort_wait_n", 32'(wait_n), 32'd1);
        check("abort_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        tick();
        mem_read(16'h0000, 8'h11, "abort_no_write");

        // Strobes already low while reset falls: counts as a fresh cycle.
        reset = 1'b1;
        A = 16'h2000; cpu_dout = 8'h42; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        reset = 1'b0;
        hold_cycles(3, waits);
        idle_bus(); tick();
        check("restart_wr_count", 32'(wr_count), 32'd1);
        mem_read(16'h2000, 8'h42, "restart_write");

        A = 16'h3000; cpu_dout = 8'h81; mreq_n = 1'b0; wr_n = 1'b0;
        hold_cycles(MEM_WS + 1, waits);
        cpu_dout = 8'h99;
        hold_cycles(5, waits);
        idle_bus(); tick();
        mem_read(16'h3000, 8'h81, "long_hold_data");
        check("long_hold_wr_count", 32'(wr_count), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
